// File: rtl/mux_display_scan_ctrl_if.sv
// Display word write channel between the PLB slave register logic and the
// scan controller: a plain valid/ready handshake carrying one 32-bit word.
//   wr_valid : master offers wr_data this cycle
//   wr_ready : slave shadow register is free
//   wr_data  : [0:15] hex digits, [16:19] dp, [20:23] enables, [24:27] brightness
interface mux_display_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [0:31] wr_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/mux_display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// A word is accepted into a shadow register and committed at frame end so
// updates never tear mid-frame; the active word is scanned one digit per slot
// with inter-digit blanking and per-frame brightness PWM.
// Ports:
//   SPLB_Clk, SPLB_Rst : clock, asynchronous active-high reset
//   wr (slave)         : display word handshake (wr_ready = ~pending)
//   pending            : shadow holds an uncommitted word
//   frame_done         : one-cycle pulse after the last digit-3 cycle
//   segments[0:7]      : active-low a..g, dp
//   anodes[0:3]        : active-low, anodes[i] drives digit i
//   lamp_test          : only with MUX_DISPLAY_LAMPTEST_EN defined; lights
//                        every segment of every digit after blanking
module mux_display_scan_ctrl #(
    parameter int C_DIGIT_TICKS = 65536,
    parameter int C_BLANK_TICKS = 256
) (
    input  logic                   SPLB_Clk,
    input  logic                   SPLB_Rst,
    mux_display_scan_ctrl_if.slave wr,
`ifdef MUX_DISPLAY_LAMPTEST_EN
    input  logic                   lamp_test,
`endif
    output logic                   pending,
    output logic                   frame_done,
    output logic [0:7]             segments,
    output logic [0:3]             anodes
);

    localparam int CW = $clog2(C_DIGIT_TICKS);

    logic [CW-1:0] slotCnt;
    logic [1:0]    digitIdx;
    logic [0:31]   activeWord;
    logic [0:31]   shadowWord;

    logic          slotEnd;
    logic          frameEnd;
    logic          accept;
    logic [3:0]    phase;
    logic [3:0]    bright;
    logic [3:0]    nibble;
    logic [0:3]    dpBits;
    logic [0:3]    enBits;
    logic [4:0]    nibBase;
    logic          pastBlank;
    logic          lit;
    logic [0:3]    nextAnodes;
    logic [0:7]    nextSegments;

    function automatic logic [6:0] hexFont(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0:    f = 7'b0000001;
            4'h1:    f = 7'b1001111;
            4'h2:    f = 7'b0010010;
            4'h3:    f = 7'b0000110;
            4'h4:    f = 7'b1001100;
            4'h5:    f = 7'b0100100;
            4'h6:    f = 7'b0100000;
            4'h7:    f = 7'b0001111;
            4'h8:    f = 7'b0000000;
            4'h9:    f = 7'b0000100;
            4'hA:    f = 7'b0001000;
            4'hB:    f = 7'b1100000;
            4'hC:    f = 7'b0110001;
            4'hD:    f = 7'b1000010;
            4'hE:    f = 7'b0110000;
            default: f = 7'b0111000;
        endcase
        return f;
    endfunction

    assign wr.wr_ready = ~pending;
    assign accept      = wr.wr_valid & ~pending;
    assign slotEnd     = (slotCnt == CW'(C_DIGIT_TICKS - 1));
    assign frameEnd    = slotEnd && (digitIdx == 2'd3);

    // PWM phase is the slot position in sixteenths.
    assign phase     = slotCnt[CW-1 -: 4];
    assign bright    = activeWord[24:27];
    assign dpBits    = activeWord[16:19];
    assign enBits    = activeWord[20:23];
    assign nibBase   = {1'b0, digitIdx, 2'b00};
    assign nibble    = activeWord[nibBase +: 4];
    assign pastBlank = (slotCnt >= CW'(C_BLANK_TICKS));

    always_comb begin
        lit          = pastBlank && (phase <= bright) && enBits[digitIdx];
        nextSegments = {hexFont(nibble), ~dpBits[digitIdx]};
`ifdef MUX_DISPLAY_LAMPTEST_EN
        if (lamp_test) begin
            lit          = pastBlank;
            nextSegments = 8'h00;
        end
`endif
        nextAnodes = 4'b1111;
        if (lit) begin
            nextAnodes[digitIdx] = 1'b0;
        end else begin
            nextSegments = 8'hFF;
        end
    end

    always_ff @(posedge SPLB_Clk or posedge SPLB_Rst) begin
        if (SPLB_Rst) begin
            slotCnt    <= '0;
            digitIdx   <= 2'd0;
            activeWord <= '0;
            shadowWord <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            anodes     <= 4'b1111;
            segments   <= 8'hFF;
        end else begin
            // Power-of-two slot length: the counter wraps on its own.
            slotCnt    <= slotCnt + CW'(1);
            if (slotEnd) begin
                digitIdx <= digitIdx + 2'd1;
            end
            frame_done <= frameEnd;
            // accept needs pending=0, so it never collides with a commit;
            // a word accepted on frame end waits for the next one.
            if (frameEnd && pending) begin
                activeWord <= shadowWord;
                pending    <= 1'b0;
            end
            if (accept) begin
                shadowWord <= wr.wr_data;
                pending    <= 1'b1;
            end
            anodes     <= nextAnodes;
            segments   <= nextSegments;
        end
    end

endmodule
